// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: default parameters, instruction field
// positions and the fetch FSM state encoding.
package fetch_stage_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    localparam int OP_LSB = 0;
    localparam int OP_MSB = 6;
    localparam int F3_LSB = 12;
    localparam int F3_MSB = 14;
    localparam int F7_LSB = 25;
    localparam int F7_MSB = 31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_KILL  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and memory (slave).
interface fetch_stage_if #(
    parameter int XLEN = 32
);
    // Handshake: the master raises imem_req and holds imem_addr stable until
    // imem_valid is seen high on a rising edge; the slave may answer in the same
    // cycle. imem_rdata is meaningful only while imem_valid=1.
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a new instruction, insert a NOP bubble, or hold.
// Bubble wins over load so a redirect always squashes the slot.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int          XLEN      = XLEN_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            bubble,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc
);

    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (bubble) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = in_instr;
            pc_d    = in_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, one-outstanding-request memory FSM, one-entry skid
// buffer for stalls, branch redirect/kill, and the IF/ID register with decoded fields.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    fetch_stage_if.master     imem,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [XLEN-1:0]   branch_target,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [XLEN-1:0]   if_pc,
    output logic [XLEN-1:0]   if_pc_plus4,
    output logic [6:0]        Op,
    output logic [2:0]        funct3,
    output logic [6:0]        funct7,
    output fetch_state_e      dbg_state
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] kill_addr_q, kill_addr_d;
    logic            skid_valid_q, skid_valid_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;

    logic            ifid_load;
    logic            ifid_bubble;
    logic [31:0]     ifid_instr;
    logic [XLEN-1:0] ifid_pc;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_addr_d  = kill_addr_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        ifid_load    = 1'b0;
        ifid_bubble  = 1'b0;
        ifid_instr   = imem.imem_rdata;
        ifid_pc      = pc_q;

        if (branch_taken) begin
            pc_d         = branch_target;
            ifid_bubble  = 1'b1;
            skid_valid_d = 1'b0;
            // An unanswered request must still be completed at its old address.
            unique case (state_q)
                ST_FETCH: begin
                    if (!imem.imem_valid) begin
                        state_d     = ST_KILL;
                        kill_addr_d = pc_q;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                ST_KILL:  state_d = imem.imem_valid ? ST_FETCH : ST_KILL;
                default:  state_d = ST_FETCH;
            endcase
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_FETCH;
                    if (!stall) ifid_bubble = 1'b1;
                end
                ST_FETCH: begin
                    if (imem.imem_valid) begin
                        pc_d = pc_q + XLEN'(4);
                        if (stall) begin
                            skid_valid_d = 1'b1;
                            skid_instr_d = imem.imem_rdata;
                            skid_pc_d    = pc_q;
                            state_d      = ST_HOLD;
                        end else begin
                            ifid_load = 1'b1;
                        end
                    end else if (!stall) begin
                        ifid_bubble = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        ifid_load    = skid_valid_q;
                        ifid_instr   = skid_instr_q;
                        ifid_pc      = skid_pc_q;
                        skid_valid_d = 1'b0;
                        state_d      = ST_FETCH;
                    end
                end
                ST_KILL: begin
                    ifid_bubble = 1'b1;
                    if (imem.imem_valid) state_d = ST_FETCH;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            kill_addr_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_addr_q  <= kill_addr_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    // In KILL the PC already holds the redirect target; the bus keeps the old address.
    assign imem.imem_req  = (state_q == ST_FETCH) || (state_q == ST_KILL);
    assign imem.imem_addr = (state_q == ST_KILL) ? kill_addr_q : pc_q;

    if_id_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (ifid_load),
        .bubble    (ifid_bubble),
        .in_instr  (ifid_instr),
        .in_pc     (ifid_pc),
        .out_valid (if_valid),
        .out_instr (if_instr),
        .out_pc    (if_pc)
    );

    assign if_pc_plus4 = if_pc + XLEN'(4);
    assign Op          = if_instr[OP_MSB:OP_LSB];
    assign funct3      = if_instr[F3_MSB:F3_LSB];
    assign funct7      = if_instr[F7_MSB:F7_LSB];
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: latency-configurable memory model, expected-PC queue
// checked by a monitor, and one task per scenario.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         stall = 1'b0;
  logic         branch_taken = 1'b0;
  logic [31:0]  branch_target = '0;
  logic         if_valid;
  logic [31:0]  if_instr;
  logic [31:0]  if_pc;
  logic [31:0]  if_pc_plus4;
  logic [6:0]   op;
  logic [2:0]   funct3;
  logic [6:0]   funct7;
  fetch_state_e dbg_state;

  fetch_stage_if #(.XLEN(32)) bus ();

  fetch_stage #(
    .XLEN      (32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (bus),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_pc_plus4   (if_pc_plus4),
    .Op            (op),
    .funct3        (funct3),
    .funct7        (funct7),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- memory model ----------------
  int   mem_lat = 0;
  int   granted = 0;
  int   served = 0;
  int   wait_cnt = 0;
  logic late_valid = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0033;
  endfunction

  always @* begin
    bus.imem_rdata = mem_word(bus.imem_addr);
    bus.imem_valid = late_valid ||
                     (bus.imem_req && (granted != served) && (wait_cnt >= mem_lat));
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 0;
    end else if (!bus.imem_req || granted == served) begin
      wait_cnt <= 0;
    end else if (bus.imem_valid) begin
      wait_cnt <= 0;
      served   <= served + 1;
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic        last_valid = 1'b0;
  logic [31:0] last_pc = '0;
  logic [31:0] last_instr = NOP;

  always @(posedge clk) begin
    logic        stall_e, br_e, rst_e;
    logic [31:0] e_pc, e_instr;
    stall_e = stall;
    br_e    = branch_taken;
    rst_e   = rst;
    #1;
    if (rst || rst_e) begin
      last_valid = 1'b0;
      last_pc    = '0;
      last_instr = NOP;
    end else if (br_e) begin
      checks++;
      if (if_valid !== 1'b0 || if_instr !== NOP) begin
        errors++;
        $display("FAIL branch_squash: valid=%b instr=%h expected valid=0 instr=%h", if_valid, if_instr, NOP);
      end
    end else if (stall_e) begin
      checks++;
      if (if_valid !== last_valid || if_pc !== last_pc || if_instr !== last_instr) begin
        errors++;
        $display("FAIL stall_freeze: valid=%b pc=%h instr=%h expected valid=%b pc=%h instr=%h",
                 if_valid, if_pc, if_instr, last_valid, last_pc, last_instr);
      end
    end else if (if_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_instr: pc=%h instr=%h expected no valid instruction", if_pc, if_instr);
      end else begin
        e_pc    = exp_q.pop_front();
        e_instr = mem_word(e_pc);
        if (if_pc !== e_pc || if_instr !== e_instr || if_pc_plus4 !== e_pc + 32'd4 ||
            op !== e_instr[6:0] || funct3 !== e_instr[14:12] || funct7 !== e_instr[31:25]) begin
          errors++;
          $display("FAIL ifid_data: pc=%h instr=%h pc4=%h op=%h f3=%h f7=%h expected pc=%h instr=%h",
                   if_pc, if_instr, if_pc_plus4, op, funct3, funct7, e_pc, e_instr);
        end
      end
    end else begin
      checks++;
      if (if_valid !== 1'b0 || if_instr !== NOP) begin
        errors++;
        $display("FAIL bubble_nop: valid=%b instr=%h expected valid=0 instr=%h", if_valid, if_instr, NOP);
      end
    end
    last_valid = if_valid;
    last_pc    = if_pc;
    last_instr = if_instr;
  end

  task automatic wait_drain(input int max_cycles, input string name);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d instructions outstanding expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    mem_lat = 0;
    granted = served;
    #1;
    checks++;
    if (if_valid !== 1'b0 || if_instr !== NOP || if_pc !== 32'h0 ||
        bus.imem_req !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_values: valid=%b instr=%h pc=%h req=%b state=%0d expected 0/%h/0/0/IDLE",
               if_valid, if_instr, if_pc, bus.imem_req, dbg_state, NOP);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    @(negedge clk);
    granted = granted + 8;
    rst = 1'b0;
    #1;
    checks++;
    if (dbg_state !== ST_IDLE || bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: state=%0d req=%b expected IDLE req=0", dbg_state, bus.imem_req);
    end
    @(posedge clk); #1;
    checks++;
    if (dbg_state !== ST_FETCH || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_fetch: state=%0d req=%b addr=%h valid=%b expected FETCH/1/0/0",
               dbg_state, bus.imem_req, bus.imem_addr, if_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
      errors++;
      $display("FAIL first_valid: valid=%b pc=%h expected 1/0", if_valid, if_pc);
    end
    @(posedge clk); #1;
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h4) begin
      errors++;
      $display("FAIL second_valid: valid=%b pc=%h expected 1/4", if_valid, if_pc);
    end
    wait_drain(20, "zero_wait");
  endtask

  task automatic test_latency2();
    logic exp_v;
    @(negedge clk);
    mem_lat = 2;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'd32 + 32'(i * 4));
    granted = granted + 3;
    for (int k = 1; k <= 9; k++) begin
      logic [31:0] exp_addr;
      exp_addr = 32'd32 + 32'(((k - 1) / 3) * 4);
      #1;
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_addr) begin
        errors++;
        $display("FAIL lat2_addr: req=%b addr=%h expected 1/%h", bus.imem_req, bus.imem_addr, exp_addr);
      end
      @(posedge clk); #1;
      exp_v = (k % 3 == 0);
      checks++;
      if (if_valid !== exp_v) begin
        errors++;
        $display("FAIL lat2_pattern: cycle %0d valid=%b expected %b", k, if_valid, exp_v);
      end
      @(negedge clk);
    end
    wait_drain(5, "latency2");
  endtask

  task automatic test_stall_skid();
    @(negedge clk);
    mem_lat = 0;
    stall = 1'b1;
    exp_q.push_back(32'd44);
    granted = granted + 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (dbg_state !== ST_HOLD || bus.imem_req !== 1'b0 || if_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_state: cycle %0d state=%0d req=%b valid=%b expected HOLD/0/0",
                 k, dbg_state, bus.imem_req, if_valid);
      end
    end
    @(negedge clk);
    stall = 1'b0;
    exp_q.push_back(32'd48);
    granted = granted + 1;
    @(posedge clk); #1;
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'd44 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd48) begin
      errors++;
      $display("FAIL skid_release: valid=%b pc=%h req=%b addr=%h expected 1/2c/1/30",
               if_valid, if_pc, bus.imem_req, bus.imem_addr);
    end
    wait_drain(5, "stall_skid");
  endtask

  task automatic test_branch_kill();
    @(negedge clk);
    mem_lat = 3;
    granted = granted + 2;
    exp_q.push_back(32'h100);
    @(posedge clk);
    @(negedge clk);
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    @(posedge clk); #1;
    checks++;
    if (dbg_state !== ST_KILL || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd52) begin
      errors++;
      $display("FAIL kill_enter: state=%0d req=%b addr=%h expected KILL/1/34",
               dbg_state, bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
    branch_taken = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dbg_state !== ST_KILL || bus.imem_addr !== 32'd52) begin
      errors++;
      $display("FAIL kill_hold_addr: state=%0d addr=%h expected KILL/34", dbg_state, bus.imem_addr);
    end
    wait_drain(20, "branch_kill");
  endtask

  task automatic test_branch_stall_hold();
    @(negedge clk);
    mem_lat = 0;
    stall = 1'b1;
    granted = granted + 1;
    @(posedge clk); #1;
    checks++;
    if (dbg_state !== ST_HOLD || bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL skid_fill: state=%0d req=%b expected HOLD/0", dbg_state, bus.imem_req);
    end
    @(negedge clk);
    branch_taken  = 1'b1;
    branch_target = 32'h200;
    @(posedge clk); #1;
    checks++;
    if (dbg_state !== ST_FETCH || bus.imem_addr !== 32'h200 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL branch_in_hold: state=%0d addr=%h valid=%b expected FETCH/200/0",
               dbg_state, bus.imem_addr, if_valid);
    end
    @(negedge clk);
    branch_taken = 1'b0;
    stall = 1'b0;
    exp_q.push_back(32'h200);
    granted = granted + 1;
    wait_drain(5, "branch_stall_hold");
    @(negedge clk);
    stall = 1'b1;
  endtask

  task automatic test_reset_mid_request();
    @(negedge clk);
    mem_lat = 3;
    granted = granted + 1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h200 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h204) begin
      errors++;
      $display("FAIL pre_reset: valid=%b pc=%h req=%b addr=%h expected 1/200/1/204",
               if_valid, if_pc, bus.imem_req, bus.imem_addr);
    end
    #2;
    rst = 1'b1;
    stall = 1'b0;
    #1;
    checks++;
    if (if_valid !== 1'b0 || if_instr !== NOP || if_pc !== 32'h0 ||
        bus.imem_req !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL async_reset: valid=%b instr=%h pc=%h req=%b state=%0d expected 0/%h/0/0/IDLE",
               if_valid, if_instr, if_pc, bus.imem_req, dbg_state, NOP);
    end
    granted = served;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mem_lat = 0;
    late_valid = 1'b1;
    @(posedge clk); #1;
    late_valid = 1'b0;
    checks++;
    if (dbg_state !== ST_FETCH || bus.imem_addr !== 32'h0 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL late_valid_ignored: state=%0d addr=%h valid=%b expected FETCH/0/0",
               dbg_state, bus.imem_addr, if_valid);
    end
    @(negedge clk);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    granted = granted + 2;
    wait_drain(10, "restart");
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency2();
    test_stall_skid();
    test_branch_kill();
    test_branch_stall_hold();
    test_reset_mid_request();
    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
